ipd_queue: RTL and testbench

Parametrised pre-decode instruction queue between IF and ID. It accepts one fetched instruction per cycle with its PC and predicted PC, and computes a 6-bit pre-decode class vector at enqueue. Entries are held in a DEPTH-entry circular buffer and presented in order to ID through the valid/allow_in handshake. A branch-cancel flush empties it in one cycle, decoupling fetch from decode stalls.

---
 rtl/ipd_queue.sv | 117 +++++++++++
 tb/tb_ipd_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ipd_queue.sv
// rtl/ipd_queue.sv - pre-decode instruction queue between IF and ID
// Optional same-cycle empty bypass is enabled by defining IPQ_BYPASS_EN.
module ipd_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_WD = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_to_IPQ_valid,
  input  logic [31:0]       if_inst,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_pred_pc,
  output logic              IPQ_allow_in,
  input  logic              flush,
  input  logic              ID_allow_in,
  output logic              IPQ_to_ID_valid,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pred_pc,
  output logic [5:0]        id_class,
  output logic [PTR_WD:0]   occupancy
);

  logic [95:0]       data_mem  [DEPTH];
  logic [5:0]        class_mem [DEPTH];
  logic [PTR_WD-1:0] wr_ptr, rd_ptr;
  logic [PTR_WD:0]   count;
  logic              empty, full, push, pop, wr_en, rd_en, bypass;
  logic [5:0]        if_class;

  // Only the opcode field inst[31:15] is needed to classify the 26 supported encodings.
  function automatic logic [5:0] pre_decode(input logic [16:0] op);
    logic alu3, shift, alui, ld, st, u12, br, br_link;
    alu3    = op inside {17'h00020, 17'h00022, 17'h00024, 17'h00025, 17'h00028,
                         17'h00029, 17'h0002A, 17'h0002B, 17'h00038};
    shift   = op inside {17'h00081, 17'h00089, 17'h00091};
    alui    = op[16:7] inside {10'h00A, 10'h00D, 10'h00E};
    ld      = op[16:7] inside {10'h0A0, 10'h0A2};
    st      = op[16:7] inside {10'h0A4, 10'h0A6};
    u12     = op[16:10] inside {7'h0A, 7'h0E};
    br      = op[16:11] inside {6'h13, 6'h14, 6'h15, 6'h16, 6'h17};
    br_link = op[16:11] inside {6'h13, 6'h15};
    pre_decode = '0;
    if (!(alu3 | shift | alui | ld | st | u12 | br)) begin
      pre_decode[5] = 1'b1;
    end else begin
      pre_decode[0] = alu3 | shift | alui | ld | u12 | br_link;
      pre_decode[1] = ld;
      pre_decode[2] = st;
      pre_decode[3] = br;
      pre_decode[4] = alu3;
    end
  endfunction

  assign if_class     = pre_decode(if_inst[31:15]);
  assign empty        = (count == '0);
  assign full         = count[PTR_WD];
  assign occupancy    = count;
  assign IPQ_allow_in = ~full | ID_allow_in;

`ifdef IPQ_BYPASS_EN
  assign bypass = empty & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign push  = IF_to_IPQ_valid & IPQ_allow_in & ~flush;
  assign pop   = IPQ_to_ID_valid & ID_allow_in & ~flush;
  // A bypassed instruction taken by ID this cycle never occupies a slot.
  assign wr_en = push & ~(bypass & ID_allow_in);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_WD'(1);
      if (wr_en & ~rd_en)      count <= count + (PTR_WD+1)'(1);
      else if (rd_en & ~wr_en) count <= count - (PTR_WD+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr]  <= {if_pred_pc, if_pc, if_inst};
      class_mem[wr_ptr] <= if_class;
    end
  end

  always_comb begin
    IPQ_to_ID_valid = ~empty;
    id_inst         = '0;
    id_pc           = '0;
    id_pred_pc      = '0;
    id_class        = '0;
    if (bypass) begin
      IPQ_to_ID_valid = IF_to_IPQ_valid;
      if (IF_to_IPQ_valid) begin
        id_inst    = if_inst;
        id_pc      = if_pc;
        id_pred_pc = if_pred_pc;
        id_class   = if_class;
      end
    end else if (!empty) begin
      {id_pred_pc, id_pc, id_inst} = data_mem[rd_ptr];
      id_class                     = class_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ipd_queue.sv
// tb/tb_ipd_queue.sv - scoreboard bench for ipd_queue
// Directed vectors with hand-computed classes; a negedge monitor checks every pop.
module tb_ipd_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_to_IPQ_valid;
  logic [31:0] if_inst, if_pc, if_pred_pc;
  logic        IPQ_allow_in, flush, ID_allow_in, IPQ_to_ID_valid;
  logic [31:0] id_inst, id_pc, id_pred_pc;
  logic [5:0]  id_class;
  logic [2:0]  occupancy;

  ipd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .IF_to_IPQ_valid(IF_to_IPQ_valid), .if_inst(if_inst),
    .if_pc(if_pc), .if_pred_pc(if_pred_pc), .IPQ_allow_in(IPQ_allow_in), .flush(flush),
    .ID_allow_in(ID_allow_in), .IPQ_to_ID_valid(IPQ_to_ID_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_pred_pc(id_pred_pc), .id_class(id_class), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_occ = 0;
  logic byp_en;
  logic [101:0] exp_q[$];

  logic [31:0] insts [12] = '{32'h0280_0421, 32'h0010_0C41, 32'h2880_0000, 32'h2980_0000,
                              32'h5800_0000, 32'hFFFF_FFFF, 32'h5400_0000, 32'h1400_0001,
                              32'h001C_0000, 32'h0040_8000, 32'h2900_0000, 32'h4C00_0000};
  logic [5:0]  clss  [12] = '{6'b000001, 6'b010001, 6'b000011, 6'b000100,
                              6'b001000, 6'b100000, 6'b001001, 6'b000001,
                              6'b010001, 6'b000001, 6'b000100, 6'b001001};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic state_check(input string tag);
    logic ev;
    ev = (m_occ != 0) || (byp_en && IF_to_IPQ_valid && !flush);
    check({tag, " occupancy"}, 32'(occupancy), m_occ);
    check({tag, " valid"}, 32'(IPQ_to_ID_valid), 32'(ev));
    check({tag, " allow_in"}, 32'(IPQ_allow_in), 32'((m_occ < DEPTH) || ID_allow_in));
    if (!ev) check({tag, " empty_outputs"}, id_inst | id_pc | id_pred_pc | 32'(id_class), 0);
  endtask

  task automatic step(input logic v, input logic [31:0] inst, input logic [5:0] cls,
                      input logic [31:0] pc, input logic al, input logic fl, input string tag);
    logic acc, byp, pp;
    IF_to_IPQ_valid = v;
    if_inst = inst;
    if_pc = pc;
    if_pred_pc = pc + 32'd4;
    ID_allow_in = al;
    flush = fl;
    acc = v && !fl && ((m_occ < DEPTH) || al);
    byp = byp_en && acc && (m_occ == 0) && al;
    if (byp) exp_q.push_back({cls, pc + 32'd4, pc, inst});
    pp = !fl && (m_occ != 0) && al;
    @(posedge clk);
    if (fl) begin
      m_occ = 0;
      exp_q.delete();
    end else begin
      if (acc && !byp) begin
        exp_q.push_back({cls, pc + 32'd4, pc, inst});
        m_occ++;
      end
      if (pp) m_occ--;
    end
    #1;
    state_check(tag);
  endtask

  always @(negedge clk) begin
    if (reset && !flush && IPQ_to_ID_valid && ID_allow_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_inst", id_inst, 32'h0);
        check("unexpected_pop_valid", 32'(IPQ_to_ID_valid), 32'h0);
      end else begin
        logic [101:0] e;
        e = exp_q.pop_front();
        check("head_inst", id_inst, e[31:0]);
        check("head_pc", id_pc, e[63:32]);
        check("head_pred_pc", id_pred_pc, e[95:64]);
        check("head_class", 32'(id_class), 32'(e[101:96]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef IPQ_BYPASS_EN
    byp_en = 1'b1;
`else
    byp_en = 1'b0;
`endif
    reset = 1'b0;
    IF_to_IPQ_valid = 1'b0;
    if_inst = '0;
    if_pc = '0;
    if_pred_pc = '0;
    flush = 1'b0;
    ID_allow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    state_check("reset");
    reset = 1'b1;

    // single addi.w push, consumed next cycle
    step(1'b1, insts[0], clss[0], 32'h1C00_0000, 1'b1, 1'b0, "single_push");
    step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "single_pop");
    step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "single_empty");

    // fill to full, then push+pop while full across pointer wrap
    for (int i = 1; i <= 4; i++)
      step(1'b1, insts[i], clss[i], 32'h1C00_0100 + 32'(i * 4), 1'b0, 1'b0, "fill");
    check("full_allow_in", 32'(IPQ_allow_in), 32'h0);
    check("full_occupancy", 32'(occupancy), 32'd4);
    for (int i = 5; i <= 7; i++)
      step(1'b1, insts[i], clss[i], 32'h1C00_0100 + 32'(i * 4), 1'b1, 1'b0, "full_pushpop");
    check("full_stays", 32'(occupancy), 32'(m_occ));
    while (m_occ != 0) step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "drain_full");

    // back-to-back class vectors at one per cycle
    for (int i = 0; i < 12; i++)
      step(1'b1, insts[i], clss[i], 32'h1C00_1000 + 32'(i * 4), 1'b1, 1'b0, "class_stream");
    while (m_occ != 0) step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "drain_class");

    // flush with three held and a same-cycle push
    for (int i = 8; i < 11; i++)
      step(1'b1, insts[i], clss[i], 32'h1C00_2000 + 32'(i * 4), 1'b0, 1'b0, "pre_flush");
    step(1'b1, 32'h0010_0C41, 6'b010001, 32'h0BAD_0000, 1'b0, 1'b1, "flush");
    check("flush_occupancy", 32'(occupancy), 32'h0);
    step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "post_flush0");
    step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "post_flush1");

    // asynchronous reset mid-stream with two held
    step(1'b1, insts[2], clss[2], 32'h1C00_3000, 1'b0, 1'b0, "pre_reset0");
    step(1'b1, insts[3], clss[3], 32'h1C00_3004, 1'b0, 1'b0, "pre_reset1");
    IF_to_IPQ_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_occupancy", 32'(occupancy), 32'h0);
    check("async_reset_valid", 32'(IPQ_to_ID_valid), 32'h0);
    m_occ = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, insts[1], clss[1], 32'h1C00_4000, 1'b0, 1'b0, "first_after_reset");
    while (m_occ != 0) step(1'b0, 32'h0, 6'h0, 32'h0, 1'b1, 1'b0, "drain_end");

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
